// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: command codes, state encoding and widths.
package prog_loader_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned LEN_W   = 16;
   localparam int unsigned STATE_W = 3;

   localparam logic [BYTE_W-1:0] CMD_TEXT = 8'h54;
   localparam logic [BYTE_W-1:0] CMD_DATA = 8'h44;
   localparam logic [BYTE_W-1:0] CMD_GO   = 8'h47;

   localparam logic [STATE_W-1:0] ST_CMD    = 3'd0;
   localparam logic [STATE_W-1:0] ST_LEN_HI = 3'd1;
   localparam logic [STATE_W-1:0] ST_LEN_LO = 3'd2;
   localparam logic [STATE_W-1:0] ST_DATA   = 3'd3;
   localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
   localparam logic [STATE_W-1:0] ST_RUN    = 3'd5;
   localparam logic [STATE_W-1:0] ST_ERR    = 3'd6;

   // States in which a stream byte may be transferred
   function automatic logic state_accepts(input logic [STATE_W-1:0] st);
      return (st == ST_CMD) || (st == ST_LEN_HI) || (st == ST_LEN_LO) || (st == ST_DATA);
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory-write bus of the program loader.
interface prog_loader_if #(
   parameter int unsigned ADDR_W = 12
) ();

   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Big-endian 4-byte to 32-bit packer; flags the push that completes a word.
module prog_loader_byte_packer
   import prog_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [WORD_W-1:0] o_word_c,
   output logic              o_last_c
);

   localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

   logic [SHIFT_W-1:0] r_shift;
   logic [1:0]         r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_push) begin
         r_shift <= {r_shift[SHIFT_W-BYTE_W-1:0], i_byte};
         r_cnt   <= r_cnt + 2'd1;
      end
   end

   // The word is complete combinationally on the 4th byte so it can be latched with it
   assign o_word_c = {r_shift, i_byte};
   assign o_last_c = i_push && (r_cnt == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Streams T/D records into instruction/data memory, then releases the CPU on 'G'.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned TEXT_BASE = 0,
   parameter int unsigned DATA_BASE = 2048
) (
   input  logic             clk,
   input  logic             reset,
   prog_loader_if.slave     bus,
   output logic             cpu_reset,
   output logic             error,
   output logic [LEN_W-1:0] words_loaded
);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_nx;

   logic               r_in_ready;
   logic               r_mem_we;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [WORD_W-1:0]  r_mem_wdata;
   logic               r_cpu_reset;
   logic               r_error;
   logic [LEN_W-1:0]   r_words;
   logic [LEN_W-1:0]   r_idx;
   logic [LEN_W-1:0]   r_len;
   logic [ADDR_W-1:0]  r_base;

   logic               w_xfer;
   logic               w_push;
   logic [WORD_W-1:0]  w_word;
   logic               w_last;
   logic               w_len_zero;
   logic               w_rec_done;

   // in_ready always mirrors state_accepts(r_state), so it doubles as the accept qualifier
   assign w_xfer     = bus.in_valid && r_in_ready;
   assign w_push     = w_xfer && (r_state == ST_DATA);
   assign w_len_zero = ({r_len[LEN_W-1:BYTE_W], bus.in_data} == '0);
   assign w_rec_done = (r_idx == (r_len - LEN_W'(1)));

   prog_loader_byte_packer u_packer (
      .clk      (clk),
      .rst_n    (reset),
      .i_push   (w_push),
      .i_byte   (bus.in_data),
      .o_word_c (w_word),
      .o_last_c (w_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_CMD;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_CMD: begin
            if (w_xfer) begin
               case (bus.in_data)
                  CMD_TEXT, CMD_DATA: w_state_nx = ST_LEN_HI;
                  CMD_GO:             w_state_nx = ST_RUN;
                  default:            w_state_nx = ST_ERR;
               endcase
            end
         end
         ST_LEN_HI: if (w_xfer) w_state_nx = ST_LEN_LO;
         ST_LEN_LO: if (w_xfer) w_state_nx = w_len_zero ? ST_CMD : ST_DATA;
         ST_DATA:   if (w_last) w_state_nx = ST_WRITE;
         ST_WRITE:  w_state_nx = w_rec_done ? ST_CMD : ST_DATA;
         ST_RUN:    w_state_nx = ST_RUN;
         ST_ERR:    w_state_nx = ST_ERR;
         default:   w_state_nx = ST_ERR;
      endcase
   end

   // Registered outputs follow the next state so they line up with the state they describe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_ready  <= 1'b1;
         r_mem_we    <= 1'b0;
         r_cpu_reset <= 1'b1;
         r_error     <= 1'b0;
      end else begin
         r_in_ready  <= state_accepts(w_state_nx);
         r_mem_we    <= (w_state_nx == ST_WRITE);
         r_cpu_reset <= (w_state_nx != ST_RUN);
         r_error     <= (w_state_nx == ST_ERR);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_base      <= '0;
         r_len       <= '0;
         r_idx       <= '0;
         r_words     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         if (w_xfer && (r_state == ST_CMD)) begin
            if (bus.in_data == CMD_TEXT) r_base <= ADDR_W'(TEXT_BASE);
            if (bus.in_data == CMD_DATA) r_base <= ADDR_W'(DATA_BASE);
         end
         if (w_xfer && (r_state == ST_LEN_HI)) r_len[LEN_W-1:BYTE_W] <= bus.in_data;
         if (w_xfer && (r_state == ST_LEN_LO)) r_len[BYTE_W-1:0]     <= bus.in_data;
         if (w_last) begin
            r_mem_addr  <= r_base + ADDR_W'(r_idx);
            r_mem_wdata <= w_word;
         end
         if (r_state == ST_WRITE) begin
            r_words <= r_words + LEN_W'(1);
            r_idx   <= w_rec_done ? '0 : r_idx + LEN_W'(1);
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign cpu_reset     = r_cpu_reset;
   assign error         = r_error;
   assign words_loaded  = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued with the stimulus, popped on mem_we.
module tb_prog_loader;

   localparam int unsigned ADDR_W = 12;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_reset;
   logic        error;
   logic [15:0] words_loaded;

   int          n_tests = 0;
   int          n_fail  = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [7:0]  stream[$];
   logic        prev_ready = 1'b0;
   bit          acc;

   prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

   prog_loader #(
      .ADDR_W    (ADDR_W),
      .TEXT_BASE (0),
      .DATA_BASE (2048)
   ) dut (
      .clk          (clk),
      .reset        (rst_n),
      .bus          (bus),
      .cpu_reset    (cpu_reset),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Write monitor: every mem_we pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         check("write_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("write_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
            check("write_data", bus.mem_wdata, mon_e.data);
         end
         check("write_in_ready", 32'(bus.in_ready), 32'd0);
         check("write_cpu_reset", 32'(cpu_reset), 32'd1);
         check("pre_write_ready", 32'(prev_ready), 32'd1);
      end
      prev_ready = bus.in_ready;
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_error", 32'(error), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      check("rst_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_wdata", bus.mem_wdata, 32'd0);
      settle(2);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   // Present one byte at a negedge, hold until a transfer edge or the budget expires
   task automatic send_byte(input logic [7:0] b, input int gap, input int budget, output bit ok);
      int n;
      n = 0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = (bus.in_ready === 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_stream(input bit rnd);
      bit ok;
      foreach (stream[i]) begin
         send_byte(stream[i], rnd ? int'($urandom_range(0, 5)) : 0, 50, ok);
         check("byte_accept", 32'(ok), 32'd1);
      end
   endtask

   task automatic run_basic(input bit rnd);
      exp_q.push_back(wr_t'{addr: 12'd0, data: 32'h2010_0005});
      exp_q.push_back(wr_t'{addr: 12'd1, data: 32'h2011_0005});
      stream = '{8'h54, 8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h05,
                 8'h20, 8'h11, 8'h00, 8'h05, 8'h47};
      send_stream(rnd);
      settle(6);
      check("basic_drain", 32'(exp_q.size()), 32'd0);
      check("basic_words", 32'(words_loaded), 32'd2);
      check("basic_run_cpu_reset", 32'(cpu_reset), 32'd0);
      check("basic_run_in_ready", 32'(bus.in_ready), 32'd0);
      check("basic_error", 32'(error), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      apply_reset();
      run_basic(1'b0);

      // Single data-segment word
      apply_reset();
      exp_q.push_back(wr_t'{addr: 12'd2048, data: 32'hDEAD_BEEF});
      stream = '{8'h44, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_stream(1'b0);
      settle(6);
      check("data_drain", 32'(exp_q.size()), 32'd0);
      check("data_words", 32'(words_loaded), 32'd1);
      check("data_in_ready_after", 32'(bus.in_ready), 32'd1);
      check("data_cpu_reset", 32'(cpu_reset), 32'd1);

      // Zero-length record then go
      apply_reset();
      stream = '{8'h54, 8'h00, 8'h00, 8'h47};
      send_stream(1'b0);
      settle(6);
      check("zero_words", 32'(words_loaded), 32'd0);
      check("zero_run_cpu_reset", 32'(cpu_reset), 32'd0);
      check("zero_run_in_ready", 32'(bus.in_ready), 32'd0);

      // Bad command byte
      apply_reset();
      send_byte(8'h99, 0, 50, acc);
      check("err_first_accept", 32'(acc), 32'd1);
      settle(2);
      check("err_flag", 32'(error), 32'd1);
      check("err_in_ready", 32'(bus.in_ready), 32'd0);
      check("err_cpu_reset", 32'(cpu_reset), 32'd1);
      send_byte(8'h54, 0, 10, acc);
      check("err_ignored", 32'(acc), 32'd0);
      settle(2);
      check("err_sticky", 32'(error), 32'd1);
      check("err_words", 32'(words_loaded), 32'd0);

      // Random valid gaps through the basic stream
      apply_reset();
      run_basic(1'b1);

      // Mixed records in both segments with an empty record between
      apply_reset();
      exp_q.push_back(wr_t'{addr: 12'd2048, data: 32'h1122_3344});
      exp_q.push_back(wr_t'{addr: 12'd2049, data: 32'hA5A5_0F0F});
      exp_q.push_back(wr_t'{addr: 12'd0,    data: 32'h5566_7788});
      stream = '{8'h44, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hA5, 8'h0F, 8'h0F,
                 8'h54, 8'h00, 8'h00,
                 8'h54, 8'h00, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88, 8'h47};
      send_stream(1'b1);
      settle(6);
      check("mixed_drain", 32'(exp_q.size()), 32'd0);
      check("mixed_words", 32'(words_loaded), 32'd3);
      check("mixed_cpu_reset", 32'(cpu_reset), 32'd0);

      // Reset in the middle of a word discards it
      apply_reset();
      stream = '{8'h54, 8'h00, 8'h01, 8'hAA, 8'hBB};
      send_stream(1'b0);
      settle(2);
      apply_reset();
      exp_q.push_back(wr_t'{addr: 12'd0, data: 32'h0000_0007});
      stream = '{8'h54, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07};
      send_stream(1'b0);
      settle(6);
      check("midrst_drain", 32'(exp_q.size()), 32'd0);
      check("midrst_words", 32'(words_loaded), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the shared instruction/data memory.
REQ-002 Parameter TEXT_BASE, default 0, first word address of the .text segment.
REQ-003 Parameter DATA_BASE, default 2048, first word address of the .data segment.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  8  byte of the load stream.
REQ-007 in_valid  input  1  in_data holds a byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid && in_ready.
REQ-009 mem_we  output  1  one-cycle memory write strobe.
REQ-010 mem_addr  output  ADDR_W  word address of the write.
REQ-011 mem_wdata  output  32  write data.
REQ-012 cpu_reset  output  1  active-high hold to the CPU core; 1 while loading.
REQ-013 error  output  1  sticky protocol error flag.
REQ-014 words_loaded  output  16  total words written since reset.

Function
REQ-015 States SHALL be CMD, LEN_HI, LEN_LO, DATA, WRITE, RUN, ERR.
REQ-016 CMD: byte 0x54 ('T') selects base=TEXT_BASE, 0x44 ('D') selects base=DATA_BASE, both -> LEN_HI; 0x47 ('G') -> RUN; any other byte -> ERR.
REQ-017 LEN_HI then LEN_LO each accept one byte forming 16-bit count N, big-endian.
REQ-018 N==0 SHALL return to CMD after LEN_LO with no memory write.
REQ-019 DATA accepts bytes big-endian (first byte = bits 31:24); after the 4th accepted byte -> WRITE.
REQ-020 WRITE lasts exactly one cycle: mem_we=1, mem_addr=(base+idx) mod 2^ADDR_W, mem_wdata=assembled word, in_ready=0.
REQ-021 After WRITE, idx and words_loaded increment; if idx was N-1 -> CMD (idx cleared), else -> DATA.
REQ-022 in_ready SHALL be 1 in CMD, LEN_HI, LEN_LO, DATA; 0 in WRITE, RUN, ERR.
REQ-023 A byte presented while in_ready=0 SHALL NOT be consumed; in_data may change only after a transfer.
REQ-024 in_valid low in any accepting state SHALL stall with no state change; gaps between bytes are unlimited.
REQ-025 RUN: cpu_reset=0, mem_we=0, in_ready=0; state held until reset.
REQ-026 ERR: error=1, cpu_reset=1, in_ready=0, no writes; held until reset.
REQ-027 cpu_reset SHALL be 1 in every state except RUN.
REQ-028 Multiple T/D records in any order and count SHALL be accepted before 'G'.
REQ-029 words_loaded SHALL wrap 0xFFFF -> 0x0000.
REQ-030 Address wrap past 2^ADDR_W-1 SHALL continue at 0 without error.
REQ-031 mem_we SHALL never be asserted outside WRITE.

Reset
REQ-032 reset low SHALL immediately force state CMD, cpu_reset=1, error=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, idx=0, byte counter=0, in_ready=1 (while reset is high again).
REQ-033 reset asserted mid-record SHALL discard the partial word; no write completes.

Structure
REQ-034 Command codes (0x54, 0x44, 0x47) and the state encoding SHALL live in a shared package, prog_loader_pkg.
REQ-035 One sub-module, byte_packer (4-byte to 32-bit big-endian shift register with count), is natural; the FSM stays in prog_loader.

Verification
REQ-036 Stream 54 00 02 20 10 00 05 20 11 00 05 47 -> writes 0x20100005 @0, 0x20110005 @1; words_loaded=2; cpu_reset falls after 0x47.
REQ-037 Stream 44 00 01 DE AD BE EF -> single write 0xDEADBEEF @2048; in_ready=0 on exactly that write cycle.
REQ-038 Stream 54 00 00 47 -> no mem_we pulse; RUN reached; words_loaded=0.
REQ-039 First byte 0x99 -> error=1, in_ready=0, cpu_reset=1; further bytes ignored until reset.
REQ-040 in_valid toggled randomly (gaps of 0-5 cycles) through REQ-036 stream -> identical writes and order.
REQ-041 reset pulsed low after 2 of 4 data bytes, then stream 54 00 01 00 00 00 07 -> only write is 0x00000007 @0.
